adc_frame_seq: RTL and testbench
================================

# adc_frame_seq

Parametrised data-path sequencer between the ADC front end, the ADC-to-FIFO stage and the FIFO-to-MAC sender, all in the `sys_clk` domain. It brings the ADC up (check, configure), then loops: wait for FIFO space, read the ADC, move samples into the FIFO, and after a programmable number of reads launch one UDP frame of known length. It generalises the fixed single-read loop with these additions:
- runtime reads-per-frame;
- computed `eth_tx_len`;
- per-stage watchdog with error latch;
- clean run/stop;
- frame counter.

## Interface
Parameters:
- `CNT_W`, 8: width of reads-per-frame and read counter.
- `BYTES_PER_READ`, 64: bytes one ADC read places in fifod.
- `HDR_LEN`, 8: header bytes prepended per frame.
- `TIMEOUT`, 65535: cycles a stage may wait for its `fd_*` before error.

Ports:
- `sys_clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: level; 1 = acquire, 0 = stop at next frame boundary.
- `frame_len` in CNT_W: ADC reads per UDP frame; 0 treated as 1.
- `clr_err` in 1: pulse; leaves ERR.
- `fifo_full` in 1: fifod full flag.
- `fd_adc_check`, `fd_adc_conf`, `fd_adc_read`, `fd_adc_fifo`, `fd_fifod2mac` in 1 each: stage done.
- `fs_adc_check`, `fs_adc_conf`, `fs_adc_read`, `fs_adc_fifo`, `fs_fifod2mac` out 1 each: stage start.
- `eth_tx_len` out 12: byte length of the pending frame.
- `frame_cnt` out 16: frames sent, wraps.
- `busy` out 1: state not IDLE/ERR.
- `err` out 1: in ERR.
- `err_code` out 4: state code that timed out.

## Operation
- States are IDLE, CHECK, CONF, PREP, READ, FIFO, CONT, SEND, LAST, ERR.
- IDLE: `run`=1 -> CHECK.
- CHECK: `fd_adc_check` -> CONF.
- CONF: `fd_adc_conf` -> PREP.
- PREP:
  - if `run`=0 and `read_num`=0 -> IDLE;
  - else if `fifo_full`=0 -> READ;
  - when `read_num`=0, latch `frame_len` (0->1) into `len_l`.
- READ: `fd_adc_read` -> FIFO.
- FIFO: `fd_adc_fifo` -> CONT.
- CONT:
  - if `read_num` = `len_l`-1 -> SEND;
  - else `read_num`++ -> LAST.
- SEND: `fd_fifod2mac` -> LAST, with `read_num` <- 0 and `frame_cnt`++.
- LAST -> PREP unconditionally.
- Each `fs_*` = 1 exactly while in its state (CHECK, CONF, READ, FIFO, SEND). No other output strobes.
- Watchdog:
  - `wd` counter clears on every state change;
  - it increments while in CHECK, CONF, READ, FIFO, SEND, or PREP with `fifo_full`=1;
  - at `wd` = TIMEOUT-1 with `fd` still low -> ERR, latching `err_code` = state code.
- `fd` arriving in the same cycle as the timeout wins: normal transition, no error.
- ERR: all `fs_*` low. `clr_err` -> IDLE and clears `err_code`, `read_num`. `frame_cnt` is kept.
- `eth_tx_len` = `len_l`*BYTES_PER_READ + HDR_LEN, registered, updated on the latch cycle. It saturates at 12'hFFF.
- `run` dropping mid-frame is ignored until the frame completes. The ADC is not re-checked until the next IDLE exit.

## Timing
- Reset (synchronous, `rst`=1 at a `sys_clk` edge):
  - state IDLE; all `fs_*`, `busy`, `err` are 0;
  - `err_code`, `read_num`, `len_l`, `wd`, `frame_cnt` are 0;
  - `eth_tx_len` = HDR_LEN + BYTES_PER_READ.
- `rst` mid-stage drops `fs_*` on the next edge; no `fd` is awaited.
- `fs_x` rises the cycle after the entering edge. `fd_x` is sampled each edge, and `fs_x` falls the edge after `fd_x`=1 is seen. Latency `fd` -> `fs` low is 1 cycle.
- CONT and LAST are one cycle each. The minimum loop is PREP, READ, FIFO, CONT, LAST = 5 cycles plus sub-block latencies.
- `eth_tx_len` is stable from one cycle after leaving PREP with `read_num`=0 until the next such latch, so it always covers SEND.
- `fd` levels held high beyond one cycle must not double-advance. Each state consumes `fd` only while in that state, and LAST/CONT separate consecutive uses.

## Structure
- A shared package holds the state encoding (4-bit localparams; codes also used by `err_code`) and the default BYTES_PER_READ/HDR_LEN.
- One natural sub-module: `stage_watchdog` (counter, clear-on-change, timeout compare).
- The length multiply is a constant multiply; shift/add is acceptable.

## Test plan
- Reset, `run`=1, `frame_len`=3, all `fd` answered after 4 cycles -> CHECK, CONF, then 3 READ/FIFO pairs, one SEND; `eth_tx_len`=200; `frame_cnt`=1.
- `frame_len`=0 -> one read per frame; `eth_tx_len`=72; `frame_cnt` increments every loop.
- `fifo_full` held 1 for 100 cycles in PREP (TIMEOUT=1000) -> no READ until it drops, no error; with TIMEOUT=50 -> `err`=1, `err_code`=PREP.
- `fd_adc_read` never returns, TIMEOUT=16 -> ERR 16 cycles after READ entry, `fs_adc_read`=0; `clr_err` -> IDLE, then CHECK if `run`.
- `run`->0 during 2nd read of a 4-read frame -> frame completes, SEND occurs, then IDLE; `busy`=0.
- `rst` asserted during SEND -> next cycle all outputs at reset values; `frame_cnt`=0.

Source files
------------

// File: rtl/adc_frame_seq_pkg.sv
// rtl/adc_frame_seq_pkg.sv - state codes, default frame geometry and frame length helper
package adc_frame_seq_pkg;

  // State codes double as err_code values, so keep them stable.
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_CHECK = 4'd1;
  localparam logic [3:0] ST_CONF  = 4'd2;
  localparam logic [3:0] ST_PREP  = 4'd3;
  localparam logic [3:0] ST_READ  = 4'd4;
  localparam logic [3:0] ST_FIFO  = 4'd5;
  localparam logic [3:0] ST_CONT  = 4'd6;
  localparam logic [3:0] ST_SEND  = 4'd7;
  localparam logic [3:0] ST_LAST  = 4'd8;
  localparam logic [3:0] ST_ERR   = 4'd9;

  localparam int DEF_BYTES_PER_READ = 64;
  localparam int DEF_HDR_LEN        = 8;

  localparam logic [11:0] TX_LEN_MAX = 12'hFFF;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_CHECK = ST_CHECK,
    S_CONF  = ST_CONF,
    S_PREP  = ST_PREP,
    S_READ  = ST_READ,
    S_FIFO  = ST_FIFO,
    S_CONT  = ST_CONT,
    S_SEND  = ST_SEND,
    S_LAST  = ST_LAST,
    S_ERR   = ST_ERR
  } state_t;

  function automatic logic [11:0] calc_tx_len(input int reads, input int bytes_per_read,
                                              input int hdr_len);
    int total;
    total = reads * bytes_per_read + hdr_len;
    if (total > int'(TX_LEN_MAX)) return TX_LEN_MAX;
    return total[11:0];
  endfunction

endpackage

// File: rtl/adc_frame_seq_stage_watchdog.sv
// rtl/adc_frame_seq_stage_watchdog.sv - per-stage wait counter, cleared on every state change
module adc_frame_seq_stage_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd;

  // Holding at the limit keeps a stalled stage from wrapping back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wd <= '0;
    end else if (en && !expired) begin
      wd <= wd + WD_W'(1);
    end
  end

  assign expired = (wd == WD_MAX);

endmodule

// File: rtl/adc_frame_seq.sv
// rtl/adc_frame_seq.sv - ADC bring-up and read/fifo/send frame loop with watchdog and frame counter
module adc_frame_seq
  import adc_frame_seq_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int BYTES_PER_READ = DEF_BYTES_PER_READ,
  parameter int HDR_LEN        = DEF_HDR_LEN,
  parameter int TIMEOUT        = 65535
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             clr_err,
  input  logic             fifo_full,
  input  logic             fd_adc_check,
  input  logic             fd_adc_conf,
  input  logic             fd_adc_read,
  input  logic             fd_adc_fifo,
  input  logic             fd_fifod2mac,
  output logic             fs_adc_check,
  output logic             fs_adc_conf,
  output logic             fs_adc_read,
  output logic             fs_adc_fifo,
  output logic             fs_fifod2mac,
  output logic [11:0]      eth_tx_len,
  output logic [15:0]      frame_cnt,
  output logic             busy,
  output logic             err,
  output logic [3:0]       err_code
);

  localparam logic [11:0] TX_LEN_RST = calc_tx_len(1, BYTES_PER_READ, HDR_LEN);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] read_num;
  logic [CNT_W-1:0] len_l;
  logic [CNT_W-1:0] len_eff;
  logic             wd_en;
  logic             wd_expired;
  logic             state_chg;

  assign len_eff   = (frame_len == '0) ? CNT_W'(1) : frame_len;
  assign state_chg = (state_nxt != state);

  adc_frame_seq_stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_stage_watchdog (
    .clk     (sys_clk),
    .rst     (rst),
    .clear   (state_chg),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A done strobe wins over a timeout that expires in the same cycle.
  always_comb begin
    state_nxt    = state;
    wd_en        = 1'b0;
    fs_adc_check = 1'b0;
    fs_adc_conf  = 1'b0;
    fs_adc_read  = 1'b0;
    fs_adc_fifo  = 1'b0;
    fs_fifod2mac = 1'b0;
    busy         = (state != S_IDLE) && (state != S_ERR);
    err          = (state == S_ERR);
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        fs_adc_check = 1'b1;
        wd_en        = 1'b1;
        if (fd_adc_check)    state_nxt = S_CONF;
        else if (wd_expired) state_nxt = S_ERR;
      end
      S_CONF: begin
        fs_adc_conf = 1'b1;
        wd_en       = 1'b1;
        if (fd_adc_conf)     state_nxt = S_PREP;
        else if (wd_expired) state_nxt = S_ERR;
      end
      S_PREP: begin
        if (!run && (read_num == '0)) begin
          state_nxt = S_IDLE;
        end else if (!fifo_full) begin
          state_nxt = S_READ;
        end else begin
          wd_en = 1'b1;
          if (wd_expired) state_nxt = S_ERR;
        end
      end
      S_READ: begin
        fs_adc_read = 1'b1;
        wd_en       = 1'b1;
        if (fd_adc_read)     state_nxt = S_FIFO;
        else if (wd_expired) state_nxt = S_ERR;
      end
      S_FIFO: begin
        fs_adc_fifo = 1'b1;
        wd_en       = 1'b1;
        if (fd_adc_fifo)     state_nxt = S_CONT;
        else if (wd_expired) state_nxt = S_ERR;
      end
      S_CONT: begin
        state_nxt = (read_num == (len_l - CNT_W'(1))) ? S_SEND : S_LAST;
      end
      S_SEND: begin
        fs_fifod2mac = 1'b1;
        wd_en        = 1'b1;
        if (fd_fifod2mac)    state_nxt = S_LAST;
        else if (wd_expired) state_nxt = S_ERR;
      end
      S_LAST: begin
        state_nxt = S_PREP;
      end
      S_ERR: begin
        if (clr_err) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame length is sampled only at a frame start, so eth_tx_len holds through SEND.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      read_num   <= '0;
      len_l      <= '0;
      eth_tx_len <= TX_LEN_RST;
      frame_cnt  <= '0;
      err_code   <= '0;
    end else begin
      if ((state == S_PREP) && (read_num == '0)) begin
        len_l      <= len_eff;
        eth_tx_len <= calc_tx_len(int'(len_eff), BYTES_PER_READ, HDR_LEN);
      end
      if ((state == S_CONT) && (state_nxt == S_LAST)) begin
        read_num <= read_num + CNT_W'(1);
      end
      if ((state == S_SEND) && (state_nxt == S_LAST)) begin
        read_num  <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if ((state != S_ERR) && (state_nxt == S_ERR)) begin
        err_code <= state;
      end
      if ((state == S_ERR) && (state_nxt == S_IDLE)) begin
        read_num <= '0;
        err_code <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_seq.sv
// tb/tb_adc_frame_seq.sv - directed and randomized check of adc_frame_seq against a cycle model
module tb_adc_frame_seq;

  localparam int CNT_W      = 8;
  localparam int BPR        = 64;
  localparam int HDR        = 8;
  localparam int TB_TIMEOUT = 40;

  localparam int M_IDLE = 0, M_CHECK = 1, M_CONF = 2, M_PREP = 3, M_READ = 4;
  localparam int M_FIFO = 5, M_CONT = 6, M_SEND = 7, M_LAST = 8, M_ERR = 9;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic             run;
  logic             clr_err;
  logic             fifo_full;
  logic [CNT_W-1:0] frame_len;
  logic [4:0]       fd_vec;
  logic             fs_adc_check, fs_adc_conf, fs_adc_read, fs_adc_fifo, fs_fifod2mac;
  logic [11:0]      eth_tx_len;
  logic [15:0]      frame_cnt;
  logic             busy, err;
  logic [3:0]       err_code;
  wire  [4:0]       fs_vec = {fs_fifod2mac, fs_adc_fifo, fs_adc_read, fs_adc_conf, fs_adc_check};

  always #5 sys_clk = ~sys_clk;

  adc_frame_seq #(
    .CNT_W          (CNT_W),
    .BYTES_PER_READ (BPR),
    .HDR_LEN        (HDR),
    .TIMEOUT        (TB_TIMEOUT)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .run          (run),
    .frame_len    (frame_len),
    .clr_err      (clr_err),
    .fifo_full    (fifo_full),
    .fd_adc_check (fd_vec[0]),
    .fd_adc_conf  (fd_vec[1]),
    .fd_adc_read  (fd_vec[2]),
    .fd_adc_fifo  (fd_vec[3]),
    .fd_fifod2mac (fd_vec[4]),
    .fs_adc_check (fs_adc_check),
    .fs_adc_conf  (fs_adc_conf),
    .fs_adc_read  (fs_adc_read),
    .fs_adc_fifo  (fs_adc_fifo),
    .fs_fifod2mac (fs_fifod2mac),
    .eth_tx_len   (eth_tx_len),
    .frame_cnt    (frame_cnt),
    .busy         (busy),
    .err          (err),
    .err_code     (err_code)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
      if (n_fail >= 50) finish_run();
    end
  endtask

  // ---------------- reference model ----------------
  int          m_stage, m_wait, m_reads, m_len;
  logic [11:0] m_tx;
  logic [15:0] m_frames;
  logic [3:0]  m_code;
  bit          m_valid = 1'b0;

  function automatic int tx_len_of(input int reads);
    int b;
    b = reads * BPR + HDR;
    return (b > 4095) ? 4095 : b;
  endfunction

  function automatic bit stage_fd(input int s);
    case (s)
      M_CHECK: return fd_vec[0];
      M_CONF:  return fd_vec[1];
      M_READ:  return fd_vec[2];
      M_FIFO:  return fd_vec[3];
      M_SEND:  return fd_vec[4];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int stage_next(input int s);
    case (s)
      M_CHECK: return M_CONF;
      M_CONF:  return M_PREP;
      M_READ:  return M_FIFO;
      M_FIFO:  return M_CONT;
      default: return M_LAST;
    endcase
  endfunction

  function automatic logic [4:0] stage_strobe(input int s);
    case (s)
      M_CHECK: return 5'b00001;
      M_CONF:  return 5'b00010;
      M_READ:  return 5'b00100;
      M_FIFO:  return 5'b01000;
      M_SEND:  return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic model_step();
    int nxt;
    bit waiting;
    if (rst) begin
      m_stage  = M_IDLE;
      m_wait   = 0;
      m_reads  = 0;
      m_len    = 0;
      m_tx     = 12'(BPR + HDR);
      m_frames = '0;
      m_code   = '0;
      m_valid  = 1'b1;
      return;
    end
    nxt     = m_stage;
    waiting = 1'b0;
    case (m_stage)
      M_IDLE: if (run) nxt = M_CHECK;
      M_CHECK, M_CONF, M_READ, M_FIFO, M_SEND: begin
        waiting = 1'b1;
        if (stage_fd(m_stage)) begin
          nxt = stage_next(m_stage);
          if (m_stage == M_SEND) begin
            m_reads  = 0;
            m_frames = m_frames + 16'd1;
          end
        end else if (m_wait == TB_TIMEOUT - 1) begin
          nxt = M_ERR;
        end
      end
      M_PREP: begin
        if (m_reads == 0) begin
          m_len = (frame_len == 0) ? 1 : int'(frame_len);
          m_tx  = 12'(tx_len_of(m_len));
        end
        if (!run && m_reads == 0) nxt = M_IDLE;
        else if (!fifo_full) nxt = M_READ;
        else begin
          waiting = 1'b1;
          if (m_wait == TB_TIMEOUT - 1) nxt = M_ERR;
        end
      end
      M_CONT: begin
        if (m_reads == m_len - 1) nxt = M_SEND;
        else begin
          m_reads++;
          nxt = M_LAST;
        end
      end
      M_LAST: nxt = M_PREP;
      default: begin
        if (clr_err) begin
          nxt     = M_IDLE;
          m_code  = '0;
          m_reads = 0;
        end
      end
    endcase
    if (nxt == M_ERR && m_stage != M_ERR) m_code = 4'(m_stage);
    m_wait  = (nxt != m_stage) ? 0 : (waiting ? m_wait + 1 : m_wait);
    m_stage = nxt;
  endtask

  always @(posedge sys_clk) model_step();

  logic [4:0] e_fs;
  logic       e_busy, e_err;

  always @(negedge sys_clk) begin
    if (m_valid) begin
      e_fs   = stage_strobe(m_stage);
      e_busy = (m_stage != M_IDLE) && (m_stage != M_ERR);
      e_err  = (m_stage == M_ERR);
      n_tests++;
      if ({fs_vec, eth_tx_len, frame_cnt, busy, err, err_code} !==
          {e_fs, m_tx, m_frames, e_busy, e_err, m_code}) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t: got fs=%b len=%0d cnt=%0d busy=%b err=%b code=%0d, expected fs=%b len=%0d cnt=%0d busy=%b err=%b code=%0d",
                 $time, fs_vec, eth_tx_len, frame_cnt, busy, err, err_code,
                 e_fs, m_tx, m_frames, e_busy, e_err, m_code);
        if (n_fail >= 50) finish_run();
      end
    end
  end

  // ---------------- stimulus ----------------
  int         hi_cnt[5];
  int         rises[5];
  logic [4:0] fs_prev;
  bit         resp_rand;
  int         resp_dly;
  logic [4:0] resp_mask;
  logic [4:0] fd_force;

  task automatic tick();
    logic [4:0] fs_now;
    logic [4:0] fd_next;
    bit         resp;
    @(posedge sys_clk);
    #2;
    fs_now = fs_vec;
    for (int i = 0; i < 5; i++) begin
      hi_cnt[i] = fs_now[i] ? hi_cnt[i] + 1 : 0;
      if (fs_now[i] && !fs_prev[i]) rises[i]++;
      if (resp_rand) resp = fs_now[i] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      else resp = fs_now[i] && (hi_cnt[i] >= resp_dly);
      fd_next[i] = (resp && resp_mask[i]) || fd_force[i];
    end
    fs_prev = fs_now;
    fd_vec  = fd_next;
  endtask

  task automatic clear_rises();
    for (int i = 0; i < 5; i++) rises[i] = 0;
  endtask

  function automatic logic probe(input int k);
    if (k < 5) return fs_vec[k];
    else if (k == 5) return err;
    return !busy;
  endfunction

  task automatic wait_until(input int k, input int budget, input string name);
    int n;
    n = 0;
    while (!probe(k) && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(probe(k)), 1);
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (int'(frame_cnt) != target && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(frame_cnt), target);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  int n;
  int f0;

  initial begin
    rst       = 1'b1;
    run       = 1'b0;
    clr_err   = 1'b0;
    fifo_full = 1'b0;
    frame_len = '0;
    fd_vec    = '0;
    fs_prev   = '0;
    resp_rand = 1'b0;
    resp_dly  = 4;
    resp_mask = 5'b11111;
    fd_force  = '0;
    for (int i = 0; i < 5; i++) hi_cnt[i] = 0;
    clear_rises();
    repeat (3) tick();

    // reset values
    check("rst_fs", int'(fs_vec), 0);
    check("rst_busy_err", int'({busy, err}), 0);
    check("rst_err_code", int'(err_code), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_tx_len", int'(eth_tx_len), 72);

    // three reads per frame
    rst       = 1'b0;
    run       = 1'b1;
    frame_len = 8'd3;
    clear_rises();
    wait_frames(1, 400, "first_frame");
    check("f3_tx_len", int'(eth_tx_len), 200);
    check("f3_reads", rises[2], 3);
    check("f3_sends", rises[4], 1);
    check("f3_checks", rises[0], 1);

    // zero treated as one read per frame
    frame_len = 8'd0;
    clear_rises();
    wait_frames(4, 400, "len0_frames");
    check("len0_reads", rises[2], 3);
    check("len0_sends", rises[4], 3);
    check("len0_tx_len", int'(eth_tx_len), 72);

    // fifo full shorter than the timeout stalls without error
    wait_until(3, 50, "reach_fifo");
    fifo_full = 1'b1;
    clear_rises();
    repeat (30) tick();
    check("full_no_read", rises[2], 0);
    check("full_no_err", int'(err), 0);
    fifo_full = 1'b0;
    wait_until(2, 10, "read_after_full");

    // fifo full past the timeout errors out in PREP
    fifo_full = 1'b1;
    wait_until(5, 200, "prep_timeout");
    check("prep_err_code", int'(err_code), M_PREP);
    check("err_fs_low", int'(fs_vec), 0);
    fifo_full = 1'b0;
    pulse_clr();
    check("clr_to_idle", int'({busy, err, err_code}), 0);
    tick();
    check("idle_to_check", int'(fs_adc_check), 1);

    // ADC read never completes
    resp_mask[2] = 1'b0;
    wait_until(2, 60, "reach_read");
    n = 0;
    while (!err && n < 100) begin
      tick();
      n++;
    end
    check("read_timeout_cycles", n, TB_TIMEOUT);
    check("read_timeout_fs", int'(fs_adc_read), 0);
    check("read_err_code", int'(err_code), M_READ);
    pulse_clr();
    wait_until(0, 5, "check_after_clr");

    // done arriving on the timeout cycle wins
    wait_until(2, 60, "reach_read2");
    repeat (TB_TIMEOUT - 1) tick();
    fd_force[2] = 1'b1;
    fd_vec[2]   = 1'b1;
    tick();
    check("fd_beats_timeout", int'({err, fs_adc_fifo}), 1);
    fd_force  = '0;
    resp_mask = 5'b11111;

    // run dropped mid-frame: frame completes, then idle
    frame_len = 8'd4;
    f0 = int'(frame_cnt);
    wait_frames(f0 + 1, 300, "boundary");
    clear_rises();
    n = 0;
    while (rises[2] < 2 && n < 200) begin
      tick();
      n++;
    end
    check("second_read", rises[2], 2);
    run = 1'b0;
    wait_until(6, 400, "stop_idle");
    check("stop_frame_cnt", int'(frame_cnt), f0 + 2);
    check("stop_reads", rises[2], 4);
    check("stop_sends", rises[4], 1);
    check("stop_tx_len", int'(eth_tx_len), 264);
    repeat (5) tick();
    check("stays_idle", int'(busy), 0);

    // saturated length
    frame_len = 8'd255;
    run       = 1'b1;
    wait_until(2, 50, "sat_read");
    check("sat_tx_len", int'(eth_tx_len), 4095);

    // reset during SEND
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    frame_len = 8'd1;
    wait_frames(2, 300, "pre_rst_frames");
    resp_mask[4] = 1'b0;
    wait_until(4, 100, "reach_send");
    rst = 1'b1;
    tick();
    check("rst_send_fs", int'(fs_vec), 0);
    check("rst_send_flags", int'({busy, err, err_code}), 0);
    check("rst_send_cnt", int'(frame_cnt), 0);
    check("rst_send_len", int'(eth_tx_len), 72);
    rst       = 1'b0;
    resp_mask = 5'b11111;

    // randomized traffic against the model
    resp_rand = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst     = ($urandom_range(0, 999) == 0);
      clr_err = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 63) == 0) run = ~run;
      if ($urandom_range(0, 31) == 0) frame_len = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0) fifo_full = ~fifo_full;
    end
    rst     = 1'b0;
    clr_err = 1'b0;
    tick();
    finish_run();
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_time_limit: got expired expected done");
    finish_run();
  end

endmodule
